// File: rtl/pc_if.sv
// pc_if: fetch-side bus of pc_next_unit; master drives stall/redirect requests (stall, pc_src, pc_target, trap_req, trap_vec), slave returns pc, pc_plus4, pc_valid, redirect_pending, misaligned, misaligned_addr
interface pc_if #(parameter int XLEN = 32);
  logic stall;
  logic pc_src;
  logic [XLEN-1:0] pc_target;
  logic trap_req;
  logic [XLEN-1:0] trap_vec;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic pc_valid;
  logic redirect_pending;
  logic misaligned;
  logic [XLEN-1:0] misaligned_addr;
  modport master(
    output stall, pc_src, pc_target, trap_req, trap_vec,
    input pc, pc_plus4, pc_valid, redirect_pending, misaligned, misaligned_addr
  );
  modport slave(
    input stall, pc_src, pc_target, trap_req, trap_vec,
    output pc, pc_plus4, pc_valid, redirect_pending, misaligned, misaligned_addr
  );
endinterface

// File: rtl/pc_next_unit.sv
// pc_next_unit: registered PC with stall hold, redirect buffering across stalls, trap priority and target alignment check; ports clk, reset (sync active-high), bus (pc_if.slave: requests in, pc/status out)
module pc_next_unit #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned INC = 4,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input logic clk,
  input logic reset,
  pc_if.slave bus
);
  localparam logic [XLEN-1:0] inc_w = XLEN'(INC);
  logic [XLEN-1:0] pc_q, buf_q, mis_addr_q, pc_n;
  logic buf_v, buf_trap, valid_q, mis_q, bad, ok, rej;
  assign bus.pc = pc_q;
  assign bus.pc_plus4 = pc_q + inc_w;
  assign bus.pc_valid = valid_q;
  assign bus.redirect_pending = buf_v;
  assign bus.misaligned = mis_q;
  assign bus.misaligned_addr = mis_addr_q;
  always_comb begin
    bad = CHECK_ALIGN && (bus.pc_target[1:0] != 2'b00);
    ok = bus.pc_src && !bad;
    rej = valid_q && bus.pc_src && bad && !bus.trap_req && (bus.stall || !buf_v);
    pc_n = bus.trap_req ? bus.trap_vec : buf_v ? buf_q : ok ? bus.pc_target : bus.pc_plus4;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_VECTOR;
      valid_q <= 1'b0;
      buf_q <= '0;
      buf_v <= 1'b0;
      buf_trap <= 1'b0;
      mis_q <= 1'b0;
      mis_addr_q <= '0;
    end else if (!valid_q) begin
      valid_q <= 1'b1;
    end else begin
      mis_q <= rej;
      if (rej) mis_addr_q <= bus.pc_target;
      if (bus.stall) begin
        if (bus.trap_req) begin
          buf_q <= bus.trap_vec;
          buf_v <= 1'b1;
          buf_trap <= 1'b1;
        end else if (ok && !(buf_v && buf_trap)) begin
          buf_q <= bus.pc_target;
          buf_v <= 1'b1;
          buf_trap <= 1'b0;
        end
      end else begin
        pc_q <= pc_n;
        buf_v <= 1'b0;
        buf_trap <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_pc_next_unit.sv
// tb_pc_next_unit: directed plus randomized check of pc_next_unit against a behavioural model
module tb_pc_next_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic stall = 1'b0, pc_src = 1'b0, trap_req = 1'b0;
  logic [31:0] pc_target = '0, trap_vec = '0;
  int total = 0, bad = 0;
  bit mready = 1'b0;
  always #5 clk = ~clk;
  pc_if #(.XLEN(32)) b0 ();
  pc_if #(.XLEN(32)) b1 ();
  assign b0.stall = stall;
  assign b0.pc_src = pc_src;
  assign b0.pc_target = pc_target;
  assign b0.trap_req = trap_req;
  assign b0.trap_vec = trap_vec;
  assign b1.stall = stall;
  assign b1.pc_src = pc_src;
  assign b1.pc_target = pc_target;
  assign b1.trap_req = trap_req;
  assign b1.trap_vec = trap_vec;
  pc_next_unit #(.XLEN(32), .RESET_VECTOR(32'h100), .INC(4), .CHECK_ALIGN(1'b1)) dut0 (.clk(clk), .reset(reset), .bus(b0.slave));
  pc_next_unit #(.XLEN(32), .RESET_VECTOR(32'h100), .INC(4), .CHECK_ALIGN(1'b0)) dut1 (.clk(clk), .reset(reset), .bus(b1.slave));
  typedef struct {
    logic [31:0] pc, pend, maddr;
    bit valid, pv, pt, mis;
  } m_t;
  m_t m [2];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit misal;
      misal = pc_src && (k == 0) && (pc_target % 4 != 0);
      if (reset) begin
        m[k].pc = 32'h100;
        m[k].valid = 0;
        m[k].pv = 0;
        m[k].pt = 0;
        m[k].pend = 0;
        m[k].mis = 0;
        m[k].maddr = 0;
      end else if (!m[k].valid) begin
        m[k].valid = 1;
      end else begin
        m[k].mis = 0;
        if (!stall) begin
          if (trap_req) m[k].pc = trap_vec;
          else if (m[k].pv) m[k].pc = m[k].pend;
          else if (pc_src && !misal) m[k].pc = pc_target;
          else begin
            m[k].pc = 32'((64'(m[k].pc) + 4) % 64'h1_0000_0000);
            if (pc_src) begin
              m[k].mis = 1;
              m[k].maddr = pc_target;
            end
          end
          m[k].pv = 0;
          m[k].pt = 0;
        end else if (trap_req) begin
          m[k].pend = trap_vec;
          m[k].pv = 1;
          m[k].pt = 1;
        end else if (pc_src && misal) begin
          m[k].mis = 1;
          m[k].maddr = pc_target;
        end else if (pc_src && !(m[k].pv && m[k].pt)) begin
          m[k].pend = pc_target;
          m[k].pv = 1;
          m[k].pt = 0;
        end
      end
    end
    if (reset) mready = 1'b1;
  end
  always @(negedge clk) begin
    if (mready) begin
      chk("pc0", b0.pc, m[0].pc);
      chk("plus4_0", b0.pc_plus4, m[0].pc + 32'd4);
      chk("valid0", 32'(b0.pc_valid), 32'(m[0].valid));
      chk("pend0", 32'(b0.redirect_pending), 32'(m[0].pv));
      chk("mis0", 32'(b0.misaligned), 32'(m[0].mis));
      chk("maddr0", b0.misaligned_addr, m[0].maddr);
      chk("pc1", b1.pc, m[1].pc);
      chk("pend1", 32'(b1.redirect_pending), 32'(m[1].pv));
      chk("mis1", 32'(b1.misaligned), 32'(m[1].mis));
    end
  end
  task automatic step(input logic s, input logic p, input logic [31:0] t, input logic tr, input logic [31:0] tv);
    stall = s;
    pc_src = p;
    pc_target = t;
    trap_req = tr;
    trap_vec = tv;
    @(posedge clk);
    #1;
  endtask
  initial begin
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("rst_pc", b0.pc, 32'h100);
    chk("rst_valid", 32'(b0.pc_valid), 0);
    chk("rst_plus4", b0.pc_plus4, 32'h104);
    reset = 1'b0;
    step(0, 0, 0, 0, 0);
    chk("rel_pc", b0.pc, 32'h100);
    chk("rel_valid", 32'(b0.pc_valid), 1);
    step(0, 0, 0, 0, 0);
    chk("seq_104", b0.pc, 32'h104);
    step(0, 0, 0, 0, 0);
    chk("seq_108", b0.pc, 32'h108);
    step(0, 0, 0, 1, 32'h200);
    chk("trap_200", b0.pc, 32'h200);
    step(0, 1, 32'h400, 0, 0);
    chk("br_400", b0.pc, 32'h400);
    step(0, 1, 32'h400, 1, 32'h80);
    chk("trap_wins", b0.pc, 32'h80);
    step(0, 0, 0, 1, 32'h300);
    step(1, 1, 32'h500, 0, 0);
    chk("stall_hold", b0.pc, 32'h300);
    chk("stall_pend", 32'(b0.redirect_pending), 1);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("stall_hold3", b0.pc, 32'h300);
    step(0, 0, 0, 0, 0);
    chk("release_500", b0.pc, 32'h500);
    chk("release_pend", 32'(b0.redirect_pending), 0);
    step(0, 0, 0, 1, 32'h300);
    step(1, 1, 32'h500, 0, 0);
    step(1, 0, 0, 1, 32'h80);
    step(1, 1, 32'h600, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("release_trap", b0.pc, 32'h80);
    step(0, 0, 0, 1, 32'h40);
    step(0, 1, 32'h1002, 0, 0);
    chk("mis_pc", b0.pc, 32'h44);
    chk("mis_pulse", 32'(b0.misaligned), 1);
    chk("mis_addr", b0.misaligned_addr, 32'h1002);
    chk("nochk_pc", b1.pc, 32'h1002);
    step(0, 0, 0, 0, 0);
    chk("mis_one", 32'(b0.misaligned), 0);
    chk("mis_hold", b0.misaligned_addr, 32'h1002);
    step(0, 0, 0, 1, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 0);
    chk("wrap_pc", b0.pc, 32'h0);
    chk("wrap_plus4", b0.pc_plus4, 32'h4);
    step(1, 1, 32'h700, 0, 0);
    chk("pre_rst_pend", 32'(b0.redirect_pending), 1);
    reset = 1'b1;
    step(1, 0, 0, 0, 0);
    chk("rst_stall_pc", b0.pc, 32'h100);
    chk("rst_stall_pend", 32'(b0.redirect_pending), 0);
    reset = 1'b0;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("no_stale", b0.pc, 32'h104);
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] t;
      t = $urandom;
      if ($urandom_range(0, 1) == 0) t[1:0] = 2'b00;
      reset = ($urandom_range(0, 63) == 0);
      step($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, t,
           $urandom_range(0, 7) == 0, $urandom & 32'hFFFF_FFFC);
    end
    reset = 1'b0;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
Registered program-counter generator. It succeeds the combinational PC+4/target select with a parametrised PC register that adds stall handling, redirect buffering across stalls, and a trap-redirect path with priority. It also checks target alignment. It sits at the front of the fetch path, drives instruction-memory address, and takes redirect requests from branch/jump resolution and trap logic.

Parameters:
XLEN, 32, PC/address width in bits.
RESET_VECTOR, 0, PC value loaded on reset (XLEN bits).
INC, 4, sequential increment in bytes.
CHECK_ALIGN, 1, 1 = reject redirect targets with target[1:0] != 0; 0 = no check.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
stall  input  1  1 = hold PC this cycle.
pc_src  input  1  1 = branch/jump redirect request this cycle.
pc_target  input  XLEN  branch/jump target, valid when pc_src=1.
trap_req  input  1  1 = trap redirect request this cycle.
trap_vec  input  XLEN  trap handler address, valid when trap_req=1.
pc  output  XLEN  current PC (registered).
pc_plus4  output  XLEN  combinational pc + INC, modulo 2^XLEN.
pc_valid  output  1  0 during reset and the reset cycle; 1 from the first cycle after reset deasserts.
redirect_pending  output  1  1 = a buffered redirect is waiting for stall release.
misaligned  output  1  one-cycle pulse: rejected misaligned pc_src target.
misaligned_addr  output  XLEN  offending target, held until the next rejection or reset.

Behaviour:
- Reset (sync, any cycle, including while a redirect is pending):
  - pc <= RESET_VECTOR.
  - pc_valid <= 0; pending buffer cleared; redirect_pending <= 0.
  - misaligned <= 0; misaligned_addr <= 0.
  - Reset overrides all other inputs.
- Next-PC selection when stall=0, in priority order:
  1. trap_req=1 -> trap_vec. trap_vec is never alignment-checked.
  2. pending buffer valid -> buffered target, then clear the buffer.
  3. pc_src=1 with an aligned target -> pc_target.
  4. Otherwise -> pc + INC.
- Misaligned target:
  - Condition: pc_src=1, CHECK_ALIGN=1, pc_target[1:0] != 0, and no higher-priority source is selected.
  - Response: the target is not taken; pc <= pc + INC; misaligned=1 for exactly the next cycle; misaligned_addr <= pc_target.
- stall=1:
  - pc holds its value.
  - Redirect capture into the pending buffer:
    - trap_req=1 -> buffer <= trap_vec, marked as trap.
    - Else pc_src=1 with an aligned target -> buffer <= pc_target, unless the buffer already holds a trap.
    - Within the same class, the latest request overwrites.
    - A misaligned pc_src during stall is rejected (misaligned pulse), not buffered.
  - redirect_pending = buffer valid.
- Stall release: the first cycle with stall=0 loads the buffered target, unless a trap arrives that same cycle (trap_req wins). The buffer clears either way.
- Single-cycle latency: a request at edge N appears on pc after edge N.
- Arithmetic:
  - pc + INC wraps modulo 2^XLEN; 0xFFFFFFFC + 4 -> 0x00000000.
  - No carry-out or overflow flag.
- Simultaneous trap_req and pc_src: the trap wins and pc_src is dropped entirely (not buffered, not alignment-checked).
- pc_plus4 is always combinationally pc + INC, including while stalled and during reset.

Test Plan:
1. Reset sequencing: RESET_VECTOR=0x100; reset high 2 cycles, then free-run with no stall -> pc = 0x100 through the first cycle after release; then 0x104, 0x108. pc_valid is 0 during reset and rises one cycle after release.
2. Redirects:
   - pc=0x200, pc_src=1, pc_target=0x400 -> next pc=0x400.
   - Same cycle with trap_req=1, trap_vec=0x80 -> next pc=0x80.
3. Stall buffering:
   - stall=1 for 3 cycles with pc=0x300; pc_src pulse target=0x500 in cycle 1 -> pc holds 0x300; redirect_pending=1 from the cycle after the pulse; after stall drops, pc=0x500 and redirect_pending=0.
   - Repeat with trap_vec=0x80 in cycle 2 -> result 0x80.
4. Misaligned target: pc=0x40, pc_src=1, target=0x1002 -> pc=0x44; misaligned=1 for one cycle; misaligned_addr=0x1002. With CHECK_ALIGN=0 -> pc=0x1002.
5. Wrap and reset mid-stall:
   - pc=0xFFFFFFFC, no stall -> pc=0x00000000 and pc_plus4=0x4.
   - Buffered redirect pending, reset asserted -> pc=RESET_VECTOR and redirect_pending=0; the buffered target is never taken.
